// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 timing constants and the shared position type.
package vga_timing_pkg;
    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;
    localparam int DEF_H_TOTAL   = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL   = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int MAX_TOTAL     = 1024;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
    } pos_t;
endpackage

// File: rtl/sync_counter.sv
// sync_counter: 10-bit modulo-TOTAL counter exposing its next value and a terminal-count strobe.
module sync_counter #(
    parameter int TOTAL = 800
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    input  logic       en,
    output logic [9:0] count,
    output logic [9:0] count_next,
    output logic       tc
);
    always_comb begin
        tc = en && (count == 10'(TOTAL - 1));
        count_next = tc ? '0 : count + {9'd0, en};
    end

    always_ff @(posedge vga_clk) count <= reset_n ? count_next : '0;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA position, sync, blank and frame strobes; every flag is decoded
// from the next position so it lands in the same cycle as DrawX/DrawY.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] HS_LO = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_HI = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_LO = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_HI = 10'(V_VISIBLE + V_FP + V_SYNC - 1);
    localparam logic [9:0] H_VIS = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS = 10'(V_VISIBLE);

    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_total_check
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed %0d", MAX_TOTAL);
    end

    logic [9:0] nx;
    logic [9:0] ny;
    logic       h_tc;
    logic       v_tc;
    pos_t       nxt;

    assign nxt = '{x: nx, y: ny};

    sync_counter #(.TOTAL(H_TOTAL)) u_hcnt (
        .vga_clk    (vga_clk),
        .reset_n    (reset_n),
        .en         (1'b1),
        .count      (DrawX),
        .count_next (nx),
        .tc         (h_tc)
    );

    sync_counter #(.TOTAL(V_TOTAL)) u_vcnt (
        .vga_clk    (vga_clk),
        .reset_n    (reset_n),
        .en         (h_tc),
        .count      (DrawY),
        .count_next (ny),
        .tc         (v_tc)
    );

    // v_tc fires only on the last pixel of the last line, i.e. the edge into (0,0)
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            hs          <= 1'b1;
            vs          <= 1'b1;
            blank       <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            hs          <= !(nxt.x >= HS_LO && nxt.x <= HS_HI);
            vs          <= !(nxt.y >= VS_LO && nxt.y <= VS_HI);
            blank       <= nxt.x < H_VIS && nxt.y < V_VIS;
            line_start  <= nxt.x == '0;
            frame_start <= v_tc;
            frame_count <= frame_count + 8'(v_tc);
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: default-timing instance for line checks, shrunken 16x12 instance for
// frame, wrap and reset checks; a per-cycle scoreboard compares both against a reference model.
module tb_vga_timing_gen;
    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       bl;
        logic       ls;
        logic       fs;
        logic [7:0] fc;
    } st_t;

    localparam st_t RST_ST = '{x: 10'd0, y: 10'd0, hs: 1'b1, vs: 1'b1, bl: 1'b1, ls: 1'b0, fs: 1'b0, fc: 8'd0};

    logic       vga_clk = 1'b0;
    logic       reset_d = 1'b0;
    logic       reset_s = 1'b0;
    logic       d_hs, d_vs, d_blank, d_ls, d_fs;
    logic [9:0] d_x, d_y;
    logic [7:0] d_fc;
    logic       s_hs, s_vs, s_blank, s_ls, s_fs;
    logic [9:0] s_x, s_y;
    logic [7:0] s_fc;

    int  checks = 0;
    int  errors = 0;
    st_t qd[$];
    st_t qs[$];
    st_t md = '0;
    st_t ms = '0;
    int  d_hs_low = 0, d_hs_fall = 0, d_ls_cnt = 0;
    int  s_vs_low = 0, s_vs_fall = 0, s_blank_cnt = 0, s_fs_cnt = 0;
    logic prev_d_hs = 1'b1, prev_s_vs = 1'b1;

    always #5 vga_clk = ~vga_clk;

    vga_timing_gen dut_d (
        .vga_clk(vga_clk), .reset_n(reset_d), .hs(d_hs), .vs(d_vs), .blank(d_blank),
        .DrawX(d_x), .DrawY(d_y), .line_start(d_ls), .frame_start(d_fs), .frame_count(d_fc)
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(3)
    ) dut_s (
        .vga_clk(vga_clk), .reset_n(reset_s), .hs(s_hs), .vs(s_vs), .blank(s_blank),
        .DrawX(s_x), .DrawY(s_y), .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fc)
    );

    function automatic st_t step(st_t s, logic rn, int hv, int hf, int hsy, int hbp,
                                 int vv, int vf, int vsy, int vbp);
        int ht = hv + hf + hsy + hbp;
        int vt = vv + vf + vsy + vbp;
        int x = int'(s.x);
        int y = int'(s.y);
        int fc = int'(s.fc);
        st_t n;
        if (!rn) begin
            x = 0;
            y = 0;
            fc = 0;
        end else if (x == ht - 1) begin
            x = 0;
            if (y == vt - 1) begin
                y = 0;
                fc = (fc + 1) % 256;
            end else y = y + 1;
        end else x = x + 1;
        n.x = 10'(x);
        n.y = 10'(y);
        n.hs = !(x >= hv + hf && x < hv + hf + hsy);
        n.vs = !(y >= vv + vf && y < vv + vf + vsy);
        n.bl = x < hv && y < vv;
        n.ls = rn && x == 0;
        n.fs = rn && x == 0 && y == 0;
        n.fc = 8'(fc);
        return n;
    endfunction

    function automatic string fmt(st_t s);
        return $sformatf("x=%0d y=%0d hs=%b vs=%b blank=%b ls=%b fs=%b fc=%0d",
                         s.x, s.y, s.hs, s.vs, s.bl, s.ls, s.fs, s.fc);
    endfunction

    task automatic cmp(input string nm, input st_t a, input st_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %s, expected %s", nm, fmt(a), fmt(e));
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick(input logic rd, input logic rs);
        @(negedge vga_clk);
        reset_d = rd;
        reset_s = rs;
        md = step(md, rd, 640, 16, 96, 48, 480, 10, 2, 33);
        ms = step(ms, rs, 8, 2, 3, 3, 6, 1, 2, 3);
        qd.push_back(md);
        qs.push_back(ms);
    endtask

    task automatic settle();
        @(posedge vga_clk);
        #2;
    endtask

    initial begin
        st_t a_d, a_s;
        @(negedge vga_clk);
        forever begin
            @(posedge vga_clk);
            #1;
            a_d = {d_x, d_y, d_hs, d_vs, d_blank, d_ls, d_fs, d_fc};
            a_s = {s_x, s_y, s_hs, s_vs, s_blank, s_ls, s_fs, s_fc};
            if (qd.size() == 0 || qs.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: output present with no expected entry queued");
            end else begin
                cmp("scoreboard_dut_d", a_d, qd.pop_front());
                cmp("scoreboard_dut_s", a_s, qs.pop_front());
            end
            if (!d_hs) d_hs_low++;
            if (prev_d_hs && !d_hs && d_x == 10'd656) d_hs_fall++;
            if (d_ls) d_ls_cnt++;
            if (!s_vs) s_vs_low++;
            if (prev_s_vs && !s_vs && s_y == 10'd7 && s_x == 10'd0) s_vs_fall++;
            if (s_blank) s_blank_cnt++;
            if (s_fs) s_fs_cnt++;
            prev_d_hs = d_hs;
            prev_s_vs = s_vs;
        end
    end

    initial begin
        int a0, a1, a2, a3;
        repeat (3) tick(1'b0, 1'b0);
        settle();
        cmp("reset_state_d", {d_x, d_y, d_hs, d_vs, d_blank, d_ls, d_fs, d_fc}, RST_ST);
        cmp("reset_state_s", {s_x, s_y, s_hs, s_vs, s_blank, s_ls, s_fs, s_fc}, RST_ST);

        a0 = d_hs_low;
        a1 = d_hs_fall;
        a2 = d_ls_cnt;
        tick(1'b1, 1'b0);
        settle();
        chk("first_release_drawx", int'(d_x), 1);
        repeat (799) tick(1'b1, 1'b0);
        settle();
        chk("line_hs_low_cycles", d_hs_low - a0, 96);
        chk("line_hs_fall_at_656", d_hs_fall - a1, 1);
        chk("line_start_pulses", d_ls_cnt - a2, 1);
        chk("line_wrap_drawx", int'(d_x), 0);
        chk("line_wrap_drawy", int'(d_y), 1);
        chk("line_start_at_wrap", int'(d_ls), 1);
        chk("held_reset_drawx", int'(s_x), 0);

        a0 = s_vs_low;
        a1 = s_vs_fall;
        a2 = s_blank_cnt;
        a3 = s_fs_cnt;
        repeat (191) tick(1'b1, 1'b1);
        settle();
        chk("prewrap_drawx", int'(s_x), 15);
        chk("prewrap_drawy", int'(s_y), 11);
        chk("prewrap_frame_start", int'(s_fs), 0);
        chk("prewrap_frame_count", int'(s_fc), 0);
        tick(1'b1, 1'b1);
        settle();
        chk("wrap_drawx", int'(s_x), 0);
        chk("wrap_drawy", int'(s_y), 0);
        chk("wrap_frame_start", int'(s_fs), 1);
        chk("wrap_frame_count", int'(s_fc), 1);
        chk("frame_vs_low_cycles", s_vs_low - a0, 32);
        chk("frame_vs_fall_at_line7", s_vs_fall - a1, 1);
        chk("frame_blank_cycles", s_blank_cnt - a2, 48);
        chk("frame_start_pulses", s_fs_cnt - a3, 1);

        a3 = s_fs_cnt;
        repeat (254 * 192) tick(1'b1, 1'b1);
        settle();
        chk("count_255", int'(s_fc), 255);
        chk("count_255_frame_start", int'(s_fs), 1);
        repeat (192) tick(1'b1, 1'b1);
        settle();
        chk("count_wrap_zero", int'(s_fc), 0);
        chk("count_wrap_frame_start", int'(s_fs), 1);
        chk("count_wrap_pulses", s_fs_cnt - a3, 255);

        repeat (245) tick(1'b1, 1'b1);
        settle();
        chk("midframe_drawx", int'(s_x), 5);
        chk("midframe_drawy", int'(s_y), 3);
        chk("midframe_count", int'(s_fc), 1);
        a3 = s_fs_cnt;
        repeat (3) tick(1'b1, 1'b0);
        settle();
        cmp("midframe_reset_state", {s_x, s_y, s_hs, s_vs, s_blank, s_ls, s_fs, s_fc}, RST_ST);
        chk("midframe_reset_no_fs", s_fs_cnt - a3, 0);
        tick(1'b1, 1'b1);
        settle();
        chk("resume_drawx", int'(s_x), 1);
        chk("resume_count", int'(s_fc), 0);
        repeat (191) tick(1'b1, 1'b1);
        settle();
        chk("resume_wrap_frame_start", int'(s_fs), 1);
        chk("resume_wrap_count", int'(s_fc), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
